// File: rtl/fifo_axis_drain.sv
// fifo_axis_drain: drains a registered-read FIFO into an AXI-Stream master through a 3-entry skid buffer,
// framing the stream into PKT_LEN-beat packets.
module fifo_axis_drain #(
    parameter int DATA_W  = 8,
    parameter int PKT_LEN = 4
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              pkt_done
);
    localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;

    logic [DATA_W-1:0] mem_q [3];
    logic [1:0]        occ_q, occ_d, head_q, head_d, tail_q, tail_d;
    logic              inflight_q, run_q, pkt_done_q, pkt_done_d, pop;
    logic [BW-1:0]     beat_q, beat_d;

    // run_q keeps reads off until the first edge after reset releases
    assign fifo_rd       = run_q && en && !fifo_empty && ({1'b0, occ_q} + {2'b0, inflight_q} < 3'd3);
    assign m_axis_tvalid = occ_q != 2'd0;
    assign m_axis_tdata  = m_axis_tvalid ? mem_q[head_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && beat_q == BW'(PKT_LEN - 1);
    assign pkt_done      = pkt_done_q;
    assign pop           = m_axis_tvalid && m_axis_tready;

    always_comb begin
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        head_d     = pop ? (head_q == 2'd2 ? 2'd0 : head_q + 2'd1) : head_q;
        tail_d     = inflight_q ? (tail_q == 2'd2 ? 2'd0 : tail_q + 2'd1) : tail_q;
        beat_d     = pop ? (m_axis_tlast ? '0 : beat_q + 1'b1) : beat_q;
        pkt_done_d = pop && m_axis_tlast;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
            pkt_done_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_q     <= beat_d;
            inflight_q <= fifo_rd;
            run_q      <= 1'b1;
            pkt_done_q <= pkt_done_d;
        end
    end

    // read data lands one cycle after the strobe, so capture on the in-flight flag
    always_ff @(posedge clock) begin
        if (inflight_q) mem_q[tail_q] <= fifo_data;
    end
endmodule

// File: tb/tb_fifo_axis_drain.sv
// tb_fifo_axis_drain: random and directed stimulus against a queue-based model of the drain;
// a PKT_LEN=4 and a PKT_LEN=3 instance share every input.
module tb_fifo_axis_drain;
    logic       clock = 0;
    logic       rst, en, fifo_empty, m_axis_tready;
    logic [7:0] fifo_data;
    logic       rd_a, valid_a, last_a, done_a, rd_b, valid_b, last_b, done_b;
    logic [7:0] data_a, data_b;

    logic [7:0] fifo_q[$], exp_q[$];
    int         n_tests = 0, n_fail = 0;
    int         beats, cyc, n_rd, o_hs, n_l3, n_l4, first_rd, first_v, first_hs, last_hs;
    logic [7:0] first_d, stall_d;
    logic       prev_rd, pd_a, pd_b, armed, stall, stall_l;

    always #5 clock = ~clock;

    fifo_axis_drain #(.DATA_W(8), .PKT_LEN(4)) u_a (
        .clock(clock), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(rd_a), .m_axis_tdata(data_a), .m_axis_tvalid(valid_a),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(last_a), .pkt_done(done_a)
    );

    fifo_axis_drain #(.DATA_W(8), .PKT_LEN(3)) u_b (
        .clock(clock), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(rd_b), .m_axis_tdata(data_b), .m_axis_tvalid(valid_b),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(last_b), .pkt_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] v);
        fifo_q.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic clr_obs();
        cyc = 0; n_rd = 0; o_hs = 0; n_l3 = 0; n_l4 = 0;
        first_rd = -1; first_v = -1; first_hs = -1; last_hs = -1; first_d = 0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance model and FIFO across the edge
    task automatic cycle();
        logic       ev, er, hs;
        logic [7:0] d;
        d = 0;
        @(negedge clock);
        ev = rst && (exp_q.size() > int'(prev_rd));
        er = rst && armed && en && !fifo_empty && exp_q.size() < 3;
        check("rd_a", rd_a, er);
        check("rd_b", rd_b, er);
        check("valid_a", valid_a, ev);
        check("valid_b", valid_b, ev);
        if (ev) begin
            check("data_a", data_a, exp_q[0]);
            check("data_b", data_b, exp_q[0]);
        end else if (!rst) begin
            check("rst_data", data_a, 0);
        end
        check("last_a", last_a, ev && beats % 4 == 3);
        check("last_b", last_b, ev && beats % 3 == 2);
        check("done_a", done_a, pd_a);
        check("done_b", done_b, pd_b);
        if (stall) begin
            check("hold_valid", valid_a, 1);
            check("hold_data", data_a, stall_d);
            check("hold_last", last_a, stall_l);
        end
        stall = valid_a && !m_axis_tready; stall_d = data_a; stall_l = last_a;
        cyc++;
        if (rd_a) begin n_rd++; if (first_rd < 0) first_rd = cyc; end
        if (valid_a && first_v < 0) first_v = cyc;
        if (valid_a && m_axis_tready) begin
            o_hs++; last_hs = cyc;
            if (first_hs < 0) begin first_hs = cyc; first_d = data_a; end
            if (last_a) n_l4++;
            if (last_b) n_l3++;
        end
        hs = ev && m_axis_tready;
        pd_a = hs && beats % 4 == 3;
        pd_b = hs && beats % 3 == 2;
        if (hs) begin void'(exp_q.pop_front()); beats++; end
        if (er) begin d = fifo_q.pop_front(); exp_q.push_back(d); end
        prev_rd = er;
        @(posedge clock); #1;
        if (rst) armed = 1;
        if (er) fifo_data = d;
        fifo_empty = fifo_q.size() == 0;
    endtask

    // Asserts reset between edges, checks outputs clear without a clock, then releases and arms
    task automatic do_reset();
        rst = 0; #1;
        check("rst_rd", rd_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_last", last_a, 0);
        check("rst_tdata", data_a, 0);
        check("rst_done", done_a, 0);
        exp_q.delete();
        beats = 0; prev_rd = 0; pd_a = 0; pd_b = 0; stall = 0; armed = 0;
        cycle(); cycle();
        rst = 1;
        cycle();
    endtask

    initial begin
        rst = 1; en = 0; m_axis_tready = 0; fifo_empty = 1; fifo_data = 0;
        beats = 0; prev_rd = 0; pd_a = 0; pd_b = 0; stall = 0; armed = 0;
        clr_obs();
        @(posedge clock); #1;

        // single packet from a preloaded FIFO
        en = 1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        do_reset();
        m_axis_tready = 1; clr_obs();
        repeat (8) cycle();
        check("pkt_reads", n_rd, 4);
        check("pkt_latency", first_v - first_rd, 2);
        check("pkt_beats", o_hs, 4);
        check("pkt_gap", last_hs - first_hs, 3);
        check("pkt_tlast", n_l4, 1);

        // backpressure fills the buffer, then drains gap-free
        do_reset();
        for (int i = 1; i <= 6; i++) push(8'(i * 8'h11));
        m_axis_tready = 0; clr_obs();
        repeat (6) cycle();
        check("bp_reads", n_rd, 3);
        check("bp_head", data_a, 8'h11);
        m_axis_tready = 1; clr_obs();
        repeat (10) cycle();
        check("bp_beats", o_hs, 6);
        check("bp_gap", last_hs - first_hs, 5);

        // packet framing over a non-multiple beat count
        do_reset();
        for (int i = 1; i <= 7; i++) push(8'(i));
        clr_obs();
        repeat (12) cycle();
        check("fr_beats", o_hs, 7);
        check("fr_tlast3", n_l3, 2);
        check("fr_tlast4", n_l4, 1);
        push(8'h08); push(8'h09);
        repeat (6) cycle();
        check("fr_tlast3_wrap", n_l3, 3);

        // enable drop after two reads
        do_reset();
        for (int i = 1; i <= 6; i++) push(8'(8'h20 + i));
        clr_obs();
        cycle(); cycle();
        en = 0;
        repeat (8) cycle();
        check("en_reads", n_rd, 2);
        check("en_beats", o_hs, 2);
        en = 1;
        repeat (10) cycle();
        check("en_resume", n_rd, 6);

        // reset with two buffered and one in flight
        do_reset();
        for (int i = 1; i <= 6; i++) push(8'(8'h40 + i));
        m_axis_tready = 0;
        repeat (3) cycle();
        check("pre_rst_valid", valid_a, 1);
        do_reset();
        push(8'h47); push(8'h48); push(8'h49);
        m_axis_tready = 1; clr_obs();
        repeat (10) cycle();
        check("rst_head", first_d, 8'h44);
        check("rst_beats", o_hs, 6);
        check("rst_tlast4", n_l4, 1);

        // random backpressure and enable over 200 words
        do_reset();
        for (int i = 0; i < 200; i++) push(8'($urandom));
        clr_obs();
        for (int i = 0; i < 3000 && o_hs < 200; i++) begin
            m_axis_tready = 1'($urandom % 2);
            en = ($urandom % 8) != 0;
            cycle();
        end
        check("rand_beats", o_hs, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
